// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
//   Shared constants, types and helper functions for the data-memory
//   responder of the pipelined RV32 core.
//   Contents:
//     OPC_LOAD / OPC_STORE      RV32 opcodes that request a memory access
//     F3_B/H/W/BU/HU            load/store width and sign encodings
//     dmem_state_t              responder FSM state
//     lane_replicate()          copies right-aligned store data onto every lane
//     lane_merge()              byte-enable read-modify-write merge
// ---------------------------------------------------------------------------
package dmem_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // Store data arrives right-aligned; putting it on every lane lets the
    // byte enables alone select which bytes land in the word.
    function automatic logic [31:0] lane_replicate(input logic [2:0]  funct3,
                                                   input logic [31:0] wdata);
        logic [31:0] rep;
        case (funct3[1:0])
            2'b00:   rep = {4{wdata[7:0]}};
            2'b01:   rep = {2{wdata[15:0]}};
            2'b10:   rep = wdata;
            default: rep = 32'h0000_0000;
        endcase
        return rep;
    endfunction

    // Per-byte select between the old word and the replicated store data.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  byte_en);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[i*8 +: 8] = byte_en[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// ---------------------------------------------------------------------------
// data_mem_responder_if
//   Request/response bundle between the EX/MEM stage (master) and the data
//   memory responder (slave).
//   Signals:
//     req_valid   EX/MEM slot holds a live instruction
//     req_opcode  RV32 opcode of that instruction
//     req_funct3  width/sign field
//     req_addr    effective byte address
//     req_wdata   right-aligned store data
//     stall       pipeline freeze while the access is in flight
//     rsp_valid   one-cycle completion pulse
//     data_read   aligned read word (0 for stores and errors)
//     err         misaligned or illegal access, valid with rsp_valid
// ---------------------------------------------------------------------------
interface data_mem_responder_if;

    logic        req_valid;
    logic [6:0]  req_opcode;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] data_read;
    logic        err;

    modport master (
        output req_valid, req_opcode, req_funct3, req_addr, req_wdata,
        input  stall, rsp_valid, data_read, err
    );

    modport slave (
        input  req_valid, req_opcode, req_funct3, req_addr, req_wdata,
        output stall, rsp_valid, data_read, err
    );

endinterface

// File: rtl/dmem_lane_gen.sv
// ---------------------------------------------------------------------------
// dmem_lane_gen
//   Combinational decode of a latched access: byte enables for stores plus
//   misalignment and illegal-funct3 flags for both loads and stores.
//   Ports:
//     funct3    in  3  width/sign field
//     addr_lo   in  2  byte offset within the word
//     is_store  in  1  1 = store, 0 = load
//     byte_en   out 4  lanes written by a store
//     misalign  out 1  half not on 2-byte boundary / word not on 4-byte boundary
//     illegal   out 1  funct3 not defined for this access type
// ---------------------------------------------------------------------------
module dmem_lane_gen
    import dmem_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [1:0] addr_lo,
    input  logic       is_store,
    output logic [3:0] byte_en,
    output logic       misalign,
    output logic       illegal
);

    // Lane selection and alignment both depend only on the size bits.
    always_comb begin
        byte_en  = 4'b0000;
        misalign = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                byte_en  = 4'b0001 << addr_lo;
                misalign = 1'b0;
            end
            2'b01: begin
                byte_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
                misalign = addr_lo[0];
            end
            2'b10: begin
                byte_en  = 4'b1111;
                misalign = (addr_lo != 2'b00);
            end
            default: begin
                byte_en  = 4'b0000;
                misalign = 1'b0;
            end
        endcase
    end

    // Stores only know SB/SH/SW; loads additionally allow LBU/LHU.
    always_comb begin
        illegal = 1'b0;
        if (is_store) begin
            illegal = (funct3 > F3_W);
        end else begin
            illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//   Multi-cycle data memory for the pipelined RV32 core. A load/store in the
//   EX/MEM slot is latched, held for LATENCY busy cycles with the pipeline
//   stalled, performed on the last busy edge, and reported with a one-cycle
//   rsp_valid pulse. Loads return the whole aligned word; writeback does the
//   sub-word extract.
//   Parameters:
//     DEPTH_WORDS  memory size in 32-bit words (power of two, >= 4)
//     LATENCY      busy cycles per access (>= 1)
//   Ports:
//     clk          rising-edge clock
//     rst_n        asynchronous active-low reset (memory contents kept)
//     bus          data_mem_responder_if.slave request/response bundle
//     ld_cnt       completed loads  (only with DMEM_ACCESS_CNT_EN)
//     st_cnt       completed stores (only with DMEM_ACCESS_CNT_EN)
//   Configuration macro: DMEM_ACCESS_CNT_EN adds the access counters.
// ---------------------------------------------------------------------------
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef DMEM_ACCESS_CNT_EN
    output logic [31:0]         ld_cnt,
    output logic [31:0]         st_cnt,
`endif
    data_mem_responder_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int ADR_W = IDX_W + 2;

    logic [31:0] mem [DEPTH_WORDS];

    dmem_state_t      state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [6:0]       opcode_r;
    logic [2:0]       funct3_r;
    logic [ADR_W-1:0] addr_r;
    logic [31:0]      wdata_r;
    logic             rsp_valid_r;
    logic [31:0]      data_read_r;
    logic             err_r;

    logic             mem_req_s;
    logic             is_store_s;
    logic [3:0]       byte_en_s;
    logic             misalign_s;
    logic             illegal_s;
    logic             acc_err_s;
    logic             done_s;
    logic             we_s;
    logic [IDX_W-1:0] idx_s;
    logic [31:0]      rd_word_s;
    logic [31:0]      wr_word_s;

    // Address bits above the memory size are ignored, so addresses alias.
    logic             unused_addr_hi_s;
    assign unused_addr_hi_s = ^bus.req_addr[31:ADR_W];

    // Decide whether the EX/MEM instruction needs the memory at all.
    always_comb begin
        mem_req_s = 1'b0;
        if (bus.req_valid) begin
            mem_req_s = (bus.req_opcode == OPC_LOAD) || (bus.req_opcode == OPC_STORE);
        end else begin
            mem_req_s = 1'b0;
        end
    end

    assign is_store_s = (opcode_r == OPC_STORE);
    assign idx_s      = addr_r[ADR_W-1:2];
    assign rd_word_s  = mem[idx_s];

    dmem_lane_gen u_lane_gen (
        .funct3   (funct3_r),
        .addr_lo  (addr_r[1:0]),
        .is_store (is_store_s),
        .byte_en  (byte_en_s),
        .misalign (misalign_s),
        .illegal  (illegal_s)
    );

    // Access completion and write qualification; an errored store never writes.
    always_comb begin
        acc_err_s = misalign_s | illegal_s;
        done_s    = (state_r == BUSY) && (cnt_r == CNT_W'(0));
        we_s      = 1'b0;
        if (done_s && is_store_s && !acc_err_s) begin
            we_s = 1'b1;
        end else begin
            we_s = 1'b0;
        end
        wr_word_s = lane_merge(rd_word_s, lane_replicate(funct3_r, wdata_r), byte_en_s);
    end

    // Memory array write port; the array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we_s && rst_n) begin
            mem[idx_s] <= wr_word_s;
        end
    end

    // Access FSM with latched request and registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= CNT_W'(0);
            opcode_r    <= 7'b0000000;
            funct3_r    <= 3'b000;
            addr_r      <= ADR_W'(0);
            wdata_r     <= 32'h0000_0000;
            rsp_valid_r <= 1'b0;
            data_read_r <= 32'h0000_0000;
            err_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    rsp_valid_r <= 1'b0;
                    if (mem_req_s) begin
                        opcode_r <= bus.req_opcode;
                        funct3_r <= bus.req_funct3;
                        addr_r   <= bus.req_addr[ADR_W-1:0];
                        wdata_r  <= bus.req_wdata;
                        cnt_r    <= CNT_W'(LATENCY - 1);
                        state_r  <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_r == CNT_W'(0)) begin
                        rsp_valid_r <= 1'b1;
                        err_r       <= acc_err_s;
                        if (!is_store_s && !acc_err_s) begin
                            data_read_r <= rd_word_s;
                        end else begin
                            data_read_r <= 32'h0000_0000;
                        end
                        state_r <= RESP;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                RESP: begin
                    // The slot still shows the completed instruction; ignore it.
                    rsp_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

`ifdef DMEM_ACCESS_CNT_EN
    logic [31:0] ld_cnt_r;
    logic [31:0] st_cnt_r;

    // Completed-access counters, bumped once per RESP cycle, errors included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_cnt_r <= 32'h0000_0000;
            st_cnt_r <= 32'h0000_0000;
        end else if (state_r == RESP) begin
            if (is_store_s) begin
                st_cnt_r <= st_cnt_r + 32'd1;
            end else begin
                ld_cnt_r <= ld_cnt_r + 32'd1;
            end
        end
    end

    assign ld_cnt = ld_cnt_r;
    assign st_cnt = st_cnt_r;
`endif

    // stall is combinational so the request cycle itself freezes the pipe;
    // gating with rst_n drops it the moment reset is asserted.
    assign bus.stall     = rst_n && (((state_r == IDLE) && mem_req_s) || (state_r == BUSY));
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.data_read = data_read_r;
    assign bus.err       = err_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
//   Directed self-checking bench for data_mem_responder (LATENCY=2,
//   DEPTH_WORDS=1024). Inputs change on the falling edge, outputs are
//   sampled on the falling edge (or 1 time unit after a drive).
//   Configuration macro: DMEM_ACCESS_CNT_EN enables the counter checks.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

    import dmem_pkg::*;

    localparam int LAT = 2;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    data_mem_responder_if bus ();

`ifdef DMEM_ACCESS_CNT_EN
    logic [31:0] ld_cnt;
    logic [31:0] st_cnt;
`endif

    data_mem_responder #(
        .DEPTH_WORDS (1024),
        .LATENCY     (LAT)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
`ifdef DMEM_ACCESS_CNT_EN
        .ld_cnt (ld_cnt),
        .st_cnt (st_cnt),
`endif
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One access: cycle 0 request, cycles 1..LAT busy, cycle LAT+1 response.
    task automatic access(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_opcode = opc;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        #1;
        check({tag, " stall c0"}, {31'd0, bus.stall}, 32'd1);
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            check({tag, " stall busy"}, {31'd0, bus.stall}, 32'd1);
            check({tag, " rsp busy"}, {31'd0, bus.rsp_valid}, 32'd0);
        end
        @(negedge clk);
        check({tag, " rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
        check({tag, " stall resp"}, {31'd0, bus.stall}, 32'd0);
        check({tag, " data_read"}, bus.data_read, exp_rd);
        check({tag, " err"}, {31'd0, bus.err}, {31'd0, exp_err});
        bus.req_valid = 1'b0;
        @(negedge clk);
        check({tag, " rsp drop"}, {31'd0, bus.rsp_valid}, 32'd0);
    endtask

    initial begin
        compared       = 0;
        mismatched     = 0;
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_opcode = 7'b0000000;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;

        repeat (3) @(negedge clk);
        check("reset rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("reset data_read", bus.data_read, 32'h0);
        check("reset err", {31'd0, bus.err}, 32'd0);
        check("reset stall", {31'd0, bus.stall}, 32'd0);
        rst_n = 1'b1;

        access("sw70",    OPC_STORE, F3_W, 32'h70, 32'hDEADBEEF, 32'h0, 1'b0);
        access("lw70a",   OPC_LOAD,  F3_W, 32'h70, 32'h0,        32'hDEADBEEF, 1'b0);
        access("sb71",    OPC_STORE, F3_B, 32'h71, 32'h000000AB, 32'h0, 1'b0);
        access("lw70b",   OPC_LOAD,  F3_W, 32'h70, 32'h0,        32'hDEADABEF, 1'b0);
        access("sh72",    OPC_STORE, F3_H, 32'h72, 32'h00001234, 32'h0, 1'b0);
        access("lw70c",   OPC_LOAD,  F3_W, 32'h70, 32'h0,        32'h1234ABEF, 1'b0);
        access("lw72mis", OPC_LOAD,  F3_W, 32'h72, 32'h0,        32'h0, 1'b1);
        access("sh71mis", OPC_STORE, F3_H, 32'h71, 32'h0000FFFF, 32'h0, 1'b1);
        access("lw70d",   OPC_LOAD,  F3_W, 32'h70, 32'h0,        32'h1234ABEF, 1'b0);
        access("lw_wrap", OPC_LOAD,  F3_W, 32'h1070, 32'h0,      32'h1234ABEF, 1'b0);
        access("lh_bad3", OPC_LOAD,  3'b011, 32'h70, 32'h0,      32'h0, 1'b1);
        access("sw_bad3", OPC_STORE, 3'b011, 32'h70, 32'h99999999, 32'h0, 1'b1);
        access("lw70e",   OPC_LOAD,  F3_W, 32'h70, 32'h0,        32'h1234ABEF, 1'b0);

        // Non-memory opcode: never stalls, never responds.
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_opcode = 7'b0110011;
        bus.req_funct3 = F3_W;
        bus.req_addr   = 32'h70;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("rtype stall", {31'd0, bus.stall}, 32'd0);
            check("rtype rsp", {31'd0, bus.rsp_valid}, 32'd0);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;

        // Reset in the middle of a store abandons it.
        access("sw10", OPC_STORE, F3_W, 32'h10, 32'h11223344, 32'h0, 1'b0);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_opcode = OPC_STORE;
        bus.req_funct3 = F3_W;
        bus.req_addr   = 32'h10;
        bus.req_wdata  = 32'h00000055;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst stall drop", {31'd0, bus.stall}, 32'd0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("rst rsp", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst data_read", bus.data_read, 32'h0);
`ifdef DMEM_ACCESS_CNT_EN
        check("rst ld_cnt", ld_cnt, 32'd0);
        check("rst st_cnt", st_cnt, 32'd0);
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post rst rsp", {31'd0, bus.rsp_valid}, 32'd0);

        access("lw10",    OPC_LOAD,  F3_W, 32'h10, 32'h0,        32'h11223344, 1'b0);
        access("sw20",    OPC_STORE, F3_W, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0);
        access("sh22",    OPC_STORE, F3_H, 32'h22, 32'h0000BEEF, 32'h0, 1'b0);
        access("lw20",    OPC_LOAD,  F3_W, 32'h20, 32'h0,        32'hBEEFF00D, 1'b0);
        access("ld_bad",  OPC_LOAD,  3'b111, 32'h20, 32'h0,      32'h0, 1'b1);
`ifdef DMEM_ACCESS_CNT_EN
        check("ld_cnt", ld_cnt, 32'd3);
        check("st_cnt", st_cnt, 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
